button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Upstream of the game state machine. Conditions the three raw front-panel buttons (red, blue, yellow) into debounced levels and single-cycle press/release pulses.
- Red and blue also produce auto-repeat press pulses while held, so song selection can scroll.
- Purely synchronous to the game clock. The state machine consumes only the pulse outputs.

Parameters:
- NUM_BTN, 3: number of buttons. Bit 0 = red, 1 = blue, 2 = yellow.
- DEBOUNCE_CYCLES, 500000: cycles a synchronized input must differ from the debounced level before the level flips. Legal range ≥ 2.
- HOLD_CYCLES, 25000000: cycles from press pulse to first auto-repeat pulse. Legal range ≥ 2.
- REPEAT_CYCLES, 5000000: cycles between successive auto-repeat pulses. Legal range ≥ 2.
- REPEAT_MASK, 3'b011: per-button auto-repeat enable.
- INVERT_IN, 1'b0: 1 means raw inputs are active-low and are inverted before the synchronizer.

Ports:
- clk  in  1  game clock.
- rst  in  1  asynchronous, active-low reset.
- btn_raw  in  NUM_BTN  asynchronous raw button inputs.
- en  in  1  pulse enable. Low suppresses press/release/repeat pulses; debouncing continues.
- btn_level  out  NUM_BTN  debounced level, 1 = pressed.
- btn_press  out  NUM_BTN  1-cycle pulse on debounced press and on each auto-repeat.
- btn_release  out  NUM_BTN  1-cycle pulse on debounced release.
- any_press  out  1  OR of btn_press, same cycle.

Behaviour:
- Reset (rst low, asynchronous):
  - Synchronizer flops, btn_level, btn_press, btn_release and any_press all go to 0.
  - All counters go to 0.
- Input path, per button, fully independent: optional inversion, then a 2-flop synchronizer (s1, s2). No combinational path from btn_raw to any output.
- Debounce, evaluated each clock edge:
  - If s2 == btn_level, clear deb_cnt.
  - Else if deb_cnt == DEBOUNCE_CYCLES-1: btn_level <= s2 and clear deb_cnt.
  - Else increment deb_cnt.
  - A glitch shorter than the count restarts the count; there is no partial credit.
- Latency: raw change first sampled at edge k; stable thereafter. btn_level and the matching pulse are high after edge k+DEBOUNCE_CYCLES+1.
- Pulses: registered and exactly 1 cycle wide.
  - btn_press fires in the cycle btn_level goes 0→1.
  - btn_release fires in the cycle btn_level goes 1→0.
  - Both are gated by en sampled at the same edge. Suppressed pulses are lost, not deferred.
- Auto-repeat, only for buttons with REPEAT_MASK bit set:
  - hold_cnt clears on the press edge and increments while btn_level = 1.
  - First repeat pulse fires HOLD_CYCLES cycles after the press pulse.
  - Subsequent pulses fire every REPEAT_CYCLES cycles.
  - Release clears hold_cnt and repeat phase; no repeat ever fires in or after the release cycle.
  - Buttons with the mask bit clear never repeat.
- Simultaneous events:
  - Buttons pressed in the same cycle give coincident btn_press bits.
  - any_press is the OR of btn_press.
- Counter widths: $clog2 of the respective parameter. No wrap is possible because every counter clears at its terminal value.
- Reset mid-operation: everything clears. A button still held at reset release is treated as a fresh press. Its pulse fires after edge DEBOUNCE_CYCLES+1, counting the first edge after release as edge 0.
- en low while held: btn_level still tracks the button. Repeat timing continues internally, but its pulses are suppressed. Re-asserting en does not emit a catch-up pulse.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3, en=1 unless stated):
- Clean press: btn_raw[0] 0→1 sampled at edge 0, held → btn_level[0] and btn_press[0] high after edge 5. btn_press[0] low after edge 6. any_press mirrors btn_press[0].
- Bounce: btn_raw[2] toggles 1,0,1,0 on alternate cycles, then stays 1 from edge 10 → exactly one btn_press[2], after edge 15. No release pulse.
- Auto-repeat: hold red from press pulse at cycle P for 20 cycles → btn_press[0] at P, P+8, P+11, P+14, P+17. Release gives one btn_release[0] and no further press. Yellow held 20 cycles gives only the initial pulse.
- Simultaneous: red and blue rise on the same edge → btn_press = 3'b011 in one cycle, any_press = 1 for one cycle.
- Enable gating: en=0 during red press, then en=1 while held past HOLD_CYCLES → no initial pulse, btn_level[0]=1. Repeats resume at the first boundary after en=1, with no catch-up pulse.
- Reset mid-hold: assert rst low while btn_level[0]=1 → all outputs 0 immediately. Release rst with button held → btn_press[0] after edge 5 counted from the first post-reset edge.

Source files
------------

// File: rtl/button_conditioner.sv
// Front-panel button conditioner: synchronize, debounce, and produce registered
// press/release pulses, with optional auto-repeat press pulses while a button is held.
module button_conditioner #(
    parameter int                 NUM_BTN         = 3,
    parameter int                 DEBOUNCE_CYCLES = 500000,
    parameter int                 HOLD_CYCLES     = 25000000,
    parameter int                 REPEAT_CYCLES   = 5000000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 3'b011,
    parameter logic               INVERT_IN       = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               en,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               any_press
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W = $clog2(HR_MAX);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    logic [NUM_BTN-1:0] raw_cond;
    logic [NUM_BTN-1:0] press_next;
    logic [NUM_BTN-1:0] release_next;
    logic [NUM_BTN-1:0] btn_press_reg;
    logic [NUM_BTN-1:0] btn_release_reg;
    logic               any_press_reg;

    assign raw_cond = btn_raw ^ {NUM_BTN{INVERT_IN}};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic             s1_reg;
            logic             s2_reg;
            logic             level_reg;
            logic             level_next;
            logic [DEB_W-1:0] deb_cnt_reg;
            logic [DEB_W-1:0] deb_cnt_next;
            logic             press_evt;
            logic             release_evt;
            logic             rpt_evt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1_reg      <= 1'b0;
                    s2_reg      <= 1'b0;
                    level_reg   <= 1'b0;
                    deb_cnt_reg <= '0;
                end else begin
                    s1_reg      <= raw_cond[gi];
                    s2_reg      <= s1_reg;
                    level_reg   <= level_next;
                    deb_cnt_reg <= deb_cnt_next;
                end
            end

            // Any sample agreeing with the current level restarts the count.
            always_comb begin
                level_next   = level_reg;
                deb_cnt_next = deb_cnt_reg;
                press_evt    = 1'b0;
                release_evt  = 1'b0;
                if (s2_reg == level_reg) begin
                    deb_cnt_next = '0;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    level_next   = s2_reg;
                    deb_cnt_next = '0;
                    press_evt    = s2_reg;
                    release_evt  = ~s2_reg;
                end else begin
                    deb_cnt_next = deb_cnt_reg + 1'b1;
                end
            end

            if (REPEAT_MASK[gi]) begin : g_rpt
                logic [HOLD_W-1:0] hold_cnt_reg;
                logic [HOLD_W-1:0] hold_cnt_next;
                logic              rpt_phase_reg;
                logic              rpt_phase_next;
                logic              rpt_fire;

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        hold_cnt_reg  <= '0;
                        rpt_phase_reg <= 1'b0;
                    end else begin
                        hold_cnt_reg  <= hold_cnt_next;
                        rpt_phase_reg <= rpt_phase_next;
                    end
                end

                // Level edges take priority, so a release cycle can never repeat.
                always_comb begin
                    hold_cnt_next  = hold_cnt_reg;
                    rpt_phase_next = rpt_phase_reg;
                    rpt_fire       = 1'b0;
                    if (press_evt || release_evt) begin
                        hold_cnt_next  = '0;
                        rpt_phase_next = 1'b0;
                    end else if (level_reg) begin
                        if (hold_cnt_reg == (rpt_phase_reg ? REP_LAST : HOLD_LAST)) begin
                            rpt_fire       = 1'b1;
                            hold_cnt_next  = '0;
                            rpt_phase_next = 1'b1;
                        end else begin
                            hold_cnt_next = hold_cnt_reg + 1'b1;
                        end
                    end
                end

                assign rpt_evt = rpt_fire;
            end else begin : g_no_rpt
                assign rpt_evt = 1'b0;
            end

            assign press_next[gi]   = en & (press_evt | rpt_evt);
            assign release_next[gi] = en & release_evt;
            assign btn_level[gi]    = level_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_press_reg   <= '0;
            btn_release_reg <= '0;
            any_press_reg   <= 1'b0;
        end else begin
            btn_press_reg   <= press_next;
            btn_release_reg <= release_next;
            any_press_reg   <= |press_next;
        end
    end

    assign btn_press   = btn_press_reg;
    assign btn_release = btn_release_reg;
    assign any_press   = any_press_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: expected pulses are queued per cycle
// when stimulus is driven and compared by a monitor as the outputs appear.
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int HLD = 8;
    localparam int REP = 3;

    logic       clk;
    logic       rst;
    logic [2:0] btn_raw;
    logic       en;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [2:0] btn_release;
    logic       any_press;

    typedef struct {
        int         cyc;
        logic [2:0] press;
        logic [2:0] rel;
    } exp_t;

    exp_t       sb[$];
    int         cyc;
    int         checks;
    int         errors;
    logic       mon_on;
    logic [2:0] mon_p;
    logic [2:0] mon_r;
    exp_t       mon_e;

    button_conditioner #(
        .NUM_BTN        (3),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HLD),
        .REPEAT_CYCLES  (REP),
        .REPEAT_MASK    (3'b011),
        .INVERT_IN      (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .en         (en),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .any_press  (any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: every cycle the pulses must equal the queued entry for that cycle, else zero.
    always @(negedge clk) begin
        if (mon_on) begin
            mon_p = 3'b000;
            mon_r = 3'b000;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                mon_e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event cycle %0d: expected press=%b rel=%b at cycle %0d never matched",
                         cyc, mon_e.press, mon_e.rel, mon_e.cyc);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                mon_p = mon_e.press;
                mon_r = mon_e.rel;
                $display("cycle %0d: press=%b release=%b any=%b (expected press=%b release=%b)",
                         cyc, btn_press, btn_release, any_press, mon_p, mon_r);
            end
            checks++;
            if (btn_press !== mon_p || btn_release !== mon_r || any_press !== (|mon_p)) begin
                errors++;
                $display("FAIL pulses cycle %0d: got press=%b rel=%b any=%b, required press=%b rel=%b any=%b",
                         cyc, btn_press, btn_release, any_press, mon_p, mon_r, |mon_p);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int c, input logic [2:0] p, input logic [2:0] r);
        exp_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        sb.push_back(e);
    endtask

    task automatic drain_check(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected events outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        rst     = 1'b0;
        btn_raw = 3'b000;
        en      = 1'b1;
        tick(3);
        checks++;
        if ({btn_level, btn_press, btn_release, any_press} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 0", {btn_level, btn_press, btn_release, any_press});
        end
        rst = 1'b1;
        tick(3);
        checks++;
        if ({btn_level, btn_press, btn_release, any_press} !== 10'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b, required 0", {btn_level, btn_press, btn_release, any_press});
        end
        mon_on = 1'b1;
    endtask

    task automatic test_clean_press;
        int n;
        n = cyc;
        btn_raw[0] = 1'b1;
        push_exp(n + DEB + 2, 3'b001, 3'b000);
        tick(DEB + 1);
        checks++;
        if (btn_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL clean_level_early: got %b, required 0", btn_level[0]);
        end
        tick(1);
        checks++;
        if (btn_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL clean_level: got %b, required 1", btn_level[0]);
        end
        n = cyc;
        btn_raw[0] = 1'b0;
        push_exp(n + DEB + 2, 3'b000, 3'b001);
        tick(DEB + 4);
        checks++;
        if (btn_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL clean_release_level: got %b, required 0", btn_level[0]);
        end
        drain_check("clean_press");
    endtask

    task automatic test_bounce;
        int n;
        n = cyc;
        for (int i = 0; i < 4; i++) begin
            btn_raw[2] = (i % 2 == 0);
            tick(2);
        end
        btn_raw[2] = 1'b1;
        push_exp(n + 8 + DEB + 2, 3'b100, 3'b000);
        tick(DEB + 2 + 20);
        checks++;
        if (btn_level[2] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_level: got %b, required 1", btn_level[2]);
        end
        n = cyc;
        btn_raw[2] = 1'b0;
        push_exp(n + DEB + 2, 3'b000, 3'b100);
        tick(DEB + 4);
        drain_check("bounce_yellow_hold");
    endtask

    task automatic test_auto_repeat;
        int p;
        p = cyc + DEB + 2;
        btn_raw[0] = 1'b1;
        push_exp(p, 3'b001, 3'b000);
        push_exp(p + HLD, 3'b001, 3'b000);
        push_exp(p + HLD + REP, 3'b001, 3'b000);
        push_exp(p + HLD + 2 * REP, 3'b001, 3'b000);
        push_exp(p + HLD + 3 * REP, 3'b001, 3'b000);
        tick(DEB + 2 + 14);
        btn_raw[0] = 1'b0;
        push_exp(p + 20, 3'b000, 3'b001);
        tick(DEB + 2 + 10);
        drain_check("auto_repeat");
    endtask

    task automatic test_simultaneous;
        int n;
        n = cyc;
        btn_raw[1:0] = 2'b11;
        push_exp(n + DEB + 2, 3'b011, 3'b000);
        tick(DEB + 2);
        checks++;
        if (btn_level !== 3'b011) begin
            errors++;
            $display("FAIL simul_level: got %b, required 011", btn_level);
        end
        n = cyc;
        btn_raw[1:0] = 2'b00;
        push_exp(n + DEB + 2, 3'b000, 3'b011);
        tick(DEB + 4);
        drain_check("simultaneous");
    endtask

    task automatic test_enable_gating;
        int p;
        p = cyc + DEB + 2;
        en = 1'b0;
        btn_raw[0] = 1'b1;
        tick(DEB + 2);
        checks++;
        if (btn_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL gated_level: got %b, required 1", btn_level[0]);
        end
        tick(9);
        en = 1'b1;
        push_exp(p + HLD + REP, 3'b001, 3'b000);
        push_exp(p + HLD + 2 * REP, 3'b001, 3'b000);
        push_exp(p + HLD + 3 * REP, 3'b001, 3'b000);
        tick(5);
        btn_raw[0] = 1'b0;
        push_exp(p + 20, 3'b000, 3'b001);
        tick(DEB + 2 + 4);
        drain_check("enable_gating");
    endtask

    task automatic test_reset_mid_hold;
        int r;
        btn_raw[0] = 1'b1;
        push_exp(cyc + DEB + 2, 3'b001, 3'b000);
        tick(DEB + 4);
        checks++;
        if (btn_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_level: got %b, required 1", btn_level[0]);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release, any_press} !== 10'b0) begin
            errors++;
            $display("FAIL async_reset_clear: got %b, required 0", {btn_level, btn_press, btn_release, any_press});
        end
        tick(3);
        rst = 1'b1;
        r = cyc;
        push_exp(r + DEB + 2, 3'b001, 3'b000);
        tick(DEB + 1);
        checks++;
        if (btn_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_level_early: got %b, required 0", btn_level[0]);
        end
        tick(1);
        btn_raw[0] = 1'b0;
        push_exp(cyc + DEB + 2, 3'b000, 3'b001);
        tick(DEB + 4);
        drain_check("reset_mid_hold");
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        mon_on  = 1'b0;
        rst     = 1'b0;
        en      = 1'b1;
        btn_raw = 3'b000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_simultaneous();
        test_enable_gating();
        test_reset_mid_hold();
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
